// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared register offsets, FSM encoding and ID width for the interrupt controller
package interrupt_controller_pkg;

   // Source IDs are 1..31; 0 means "no source".
   localparam int ID_W = 5;

   // Byte offsets of the register map; bits [1:0] of the address are ignored.
   localparam logic [3:0] INTC_PENDING = 4'h0;
   localparam logic [3:0] INTC_ENABLE  = 4'h4;
   localparam logic [3:0] INTC_MODE    = 4'h8;
   localparam logic [3:0] INTC_CLAIM   = 4'hC;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_INSERV = 1'b1
   } intc_state_t;

   // Word-address match against one register offset.
   function automatic logic reg_hit(input logic [3:0] addr, input logic [3:0] off);
      return addr[3:2] == off[3:2];
   endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - register bus between the CPU side and the interrupt controller
interface interrupt_controller_if;
   logic [3:0]  I_addr;
   logic        I_wen;
   logic        I_ren;
   logic [31:0] I_wdata;
   logic [31:0] O_rdata;

   modport master (
      output I_addr, I_wen, I_ren, I_wdata,
      input  O_rdata
   );

   modport slave (
      input  I_addr, I_wen, I_ren, I_wdata,
      output O_rdata
   );
endinterface

// File: rtl/interrupt_controller_irq_edge_detect.sv
// rtl/interrupt_controller_irq_edge_detect.sv - per-source optional synchroniser and rising-edge detector
module irq_edge_detect #(
   parameter bit SYNC = 1'b1
) (
   input  logic I_clk,
   input  logic I_rst,
   input  logic I_irq,
   output logic O_level,
   output logic O_rise
);

   logic w_level;
   logic r_prev;

   generate
      if (SYNC) begin : g_sync
         logic r_s1;
         logic r_s2;

         // Two-flop synchroniser for an asynchronous peripheral line.
         always_ff @(posedge I_clk) begin
            if (I_rst) begin
               r_s1 <= 1'b0;
               r_s2 <= 1'b0;
            end else begin
               r_s1 <= I_irq;
               r_s2 <= r_s1;
            end
         end

         assign w_level = r_s2;
      end else begin : g_nosync
         assign w_level = I_irq;
      end
   endgenerate

   // Previous level, used to spot 0->1 transitions.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= w_level;
      end
   end

   assign O_level = w_level;
   assign O_rise  = w_level & ~r_prev;

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - external interrupt controller with pending/enable/mode registers and claim/complete
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter bit SYNC    = 1'b1
) (
   input  logic                I_clk,
   input  logic                I_rst,
   input  logic [NUM_SRC-1:0]  I_irq,
   interrupt_controller_if.slave bus,
   output logic                O_extinterrupt,
   output logic [ID_W-1:0]     O_claimid
);

   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_mode;
   logic [ID_W-1:0]    r_claimid;
   logic               r_ext;
   logic [31:0]        r_rdata;
   intc_state_t        r_state;
   intc_state_t        w_state_next;

   logic [NUM_SRC-1:0] w_level;
   logic [NUM_SRC-1:0] w_rise;
   logic [NUM_SRC-1:0] w_set;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_active;
   logic [NUM_SRC-1:0] w_best_oh;
   logic [ID_W-1:0]    w_best_id;
   logic               w_claim;
   logic               w_complete;
   logic               w_wr_pending;
   logic               w_wr_enable;
   logic               w_wr_mode;
   logic [31:0]        w_rdata_mux;
   logic               w_unused;

   // Address bits [1:0] and write-data bits beyond the implemented sources are don't-care.
   assign w_unused = ^{bus.I_addr[1:0], bus.I_wdata};

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_src
         irq_edge_detect #(.SYNC(SYNC)) u_edge (
            .I_clk   (I_clk),
            .I_rst   (I_rst),
            .I_irq   (I_irq[g]),
            .O_level (w_level[g]),
            .O_rise  (w_rise[g])
         );
      end
   endgenerate

   assign w_wr_pending = bus.I_wen && reg_hit(bus.I_addr, INTC_PENDING);
   assign w_wr_enable  = bus.I_wen && reg_hit(bus.I_addr, INTC_ENABLE);
   assign w_wr_mode    = bus.I_wen && reg_hit(bus.I_addr, INTC_MODE);

   // Level-mode sources request while high, edge-mode sources on a rising edge.
   assign w_set    = (r_mode & w_level) | (~r_mode & w_rise);
   assign w_active = r_pending & r_enable;

   // Priority encoder: descending scan so the lowest active index is the last writer.
   always_comb begin
      w_best_id = '0;
      w_best_oh = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (w_active[k]) begin
            w_best_id    = ID_W'(k + 1);
            w_best_oh    = '0;
            w_best_oh[k] = 1'b1;
         end
      end
   end

   // Claim/complete FSM: next state and the strobes that act on it.
   always_comb begin
      w_state_next = r_state;
      w_claim      = 1'b0;
      w_complete   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.I_ren && reg_hit(bus.I_addr, INTC_CLAIM) && (w_best_id != '0)) begin
               w_claim      = 1'b1;
               w_state_next = ST_INSERV;
            end
         end
         ST_INSERV: begin
            if (bus.I_wen && reg_hit(bus.I_addr, INTC_CLAIM) &&
                (bus.I_wdata[ID_W-1:0] == r_claimid)) begin
               w_complete   = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Clears from claim and W1C lose to a same-cycle set so no request is dropped.
   assign w_clr = (w_claim ? w_best_oh : '0) |
                  (w_wr_pending ? bus.I_wdata[NUM_SRC-1:0] : '0);

   // Request, configuration and in-service registers plus the registered CPU interrupt.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_pending <= '0;
         r_enable  <= '0;
         r_mode    <= '0;
         r_claimid <= '0;
         r_ext     <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_set;
         if (w_wr_enable) begin
            r_enable <= bus.I_wdata[NUM_SRC-1:0];
         end
         if (w_wr_mode) begin
            r_mode <= bus.I_wdata[NUM_SRC-1:0];
         end
         if (w_claim) begin
            r_claimid <= w_best_id;
         end else if (w_complete) begin
            r_claimid <= '0;
         end
         r_ext <= (w_state_next == ST_IDLE) && (w_best_id != '0);
      end
   end

   // Read mux; reads see register values from before any same-cycle write.
   always_comb begin
      w_rdata_mux = '0;
      if (reg_hit(bus.I_addr, INTC_PENDING)) begin
         w_rdata_mux = 32'(r_pending);
      end else if (reg_hit(bus.I_addr, INTC_ENABLE)) begin
         w_rdata_mux = 32'(r_enable);
      end else if (reg_hit(bus.I_addr, INTC_MODE)) begin
         w_rdata_mux = 32'(r_mode);
      end else if (reg_hit(bus.I_addr, INTC_CLAIM)) begin
         w_rdata_mux = w_claim ? 32'(w_best_id) : 32'd0;
      end
   end

   // Read data register, held between reads.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_rdata <= '0;
      end else if (bus.I_ren) begin
         r_rdata <= w_rdata_mux;
      end
   end

   assign bus.O_rdata    = r_rdata;
   assign O_extinterrupt = r_ext;
   assign O_claimid      = r_claimid;

endmodule
